// File: rtl/add_pipeline_16bit.sv
// Fully pipelined nine-operand unsigned adder: one operand set per clock, four-edge latency.
// Adder tree 4+2+1 with c9 carried alongside in a delay line until the final stage.
module add_pipeline_16bit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] c3,
  input  logic [DATA_W-1:0] c4,
  input  logic [DATA_W-1:0] c5,
  input  logic [DATA_W-1:0] c6,
  input  logic [DATA_W-1:0] c7,
  input  logic [DATA_W-1:0] c8,
  input  logic [DATA_W-1:0] c9,
  output logic [SUM_W-1:0]  sum
);

  localparam int unsigned PW = DATA_W + 1;
  localparam int unsigned QW = DATA_W + 2;
  localparam int unsigned RW = DATA_W + 3;

  logic [PW-1:0]     p1_q, p2_q, p3_q, p4_q;
  logic [QW-1:0]     q1_q, q2_q;
  logic [RW-1:0]     r_q;
  logic [DATA_W-1:0] d1_q, d2_q, d3_q;
  logic [SUM_W-1:0]  sum_q;

  logic [PW-1:0]    p1_d, p2_d, p3_d, p4_d;
  logic [QW-1:0]    q1_d, q2_d;
  logic [RW-1:0]    r_d;
  logic [SUM_W-1:0] sum_d;

  // Each stage widens by one bit so no carry is ever dropped.
  always_comb begin
    p1_d  = PW'(c1) + PW'(c2);
    p2_d  = PW'(c3) + PW'(c4);
    p3_d  = PW'(c5) + PW'(c6);
    p4_d  = PW'(c7) + PW'(c8);
    q1_d  = QW'(p1_q) + QW'(p2_q);
    q2_d  = QW'(p3_q) + QW'(p4_q);
    r_d   = RW'(q1_q) + RW'(q2_q);
    sum_d = SUM_W'(r_q) + SUM_W'(d3_q);
  end

  // Reset is active-high despite the rst_n name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p1_q  <= '0;
      p2_q  <= '0;
      p3_q  <= '0;
      p4_q  <= '0;
      d1_q  <= '0;
      q1_q  <= '0;
      q2_q  <= '0;
      d2_q  <= '0;
      r_q   <= '0;
      d3_q  <= '0;
      sum_q <= '0;
    end else begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      p3_q  <= p3_d;
      p4_q  <= p4_d;
      d1_q  <= c9;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      d2_q  <= d1_q;
      r_q   <= r_d;
      d3_q  <= d2_q;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_add_pipeline_16bit.sv
// Bench for add_pipeline_16bit: directed and random operand sets against a
// "sum of inputs three edges back, zero if reset since" reference.
module tb_add_pipeline_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] c [9];
  logic [19:0] sum;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    bit      rst;
    int unsigned total;
  } hist_t;
  hist_t hist [$];

  add_pipeline_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c1    (c[0]),
    .c2    (c[1]),
    .c3    (c[2]),
    .c4    (c[3]),
    .c5    (c[4]),
    .c6    (c[5]),
    .c7    (c[6]),
    .c8    (c[7]),
    .c9    (c[8]),
    .sum   (sum)
  );

  always #5 clk = ~clk;

  // Expected output: the set sampled three edges ago, unless any of the last four edges reset.
  function automatic logic [19:0] model_sum();
    for (int i = 0; i < hist.size(); i++) if (hist[i].rst) return 20'd0;
    return 20'(hist[0].total);
  endfunction

  task automatic check(input string tag, input logic [19:0] expected);
    tests_run++;
    assert (sum === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, sum, expected);
    end
  endtask

  // Advance one edge with the currently driven inputs, update the model, check the output.
  task automatic tick(input string tag);
    hist_t h;
    h.rst = rst_n;
    h.total = 0;
    for (int i = 0; i < 9; i++) h.total += c[i];
    @(posedge clk);
    hist.push_back(h);
    if (hist.size() > 4) void'(hist.pop_front());
    #1;
    check(tag, model_sum());
  endtask

  task automatic set_all(input logic [15:0] v);
    for (int i = 0; i < 9; i++) c[i] = v;
  endtask

  task automatic set_rand();
    for (int i = 0; i < 9; i++) c[i] = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b1;
    set_rand();
    // Seed the model with reset history so the first checks are defined.
    for (int i = 0; i < 4; i++) hist.push_back('{rst: 1'b1, total: 0});

    tick("reset_0");
    check("reset_0_const", 20'd0);
    set_rand();
    tick("reset_1");
    check("reset_1_const", 20'd0);

    rst_n = 1'b0;
    set_all(16'd0);
    for (int i = 0; i < 4; i++) tick("zeros_after_reset");

    // Ascending 1..9 then zeros.
    for (int i = 0; i < 9; i++) c[i] = 16'(i + 1);
    tick("asc_n");
    set_all(16'd0);
    tick("asc_n1");
    tick("asc_n2");
    check("asc_not_early", 20'd0);
    tick("asc_n3");
    check("asc_result", 20'h0002D);
    tick("asc_n4");
    check("asc_flushed", 20'd0);

    // Maximum operands.
    set_all(16'hFFFF);
    tick("max_n");
    set_all(16'd0);
    for (int i = 0; i < 3; i++) tick("max_wait");
    check("max_result", 20'h8FFF7);

    // c9 delay path and c1 tree path at the same latency.
    c[8] = 16'h1234;
    tick("c9_n");
    c[8] = 16'd0;
    c[0] = 16'hFFFF;
    tick("c1_n");
    c[0] = 16'd0;
    tick("c_wait");
    tick("c9_out");
    check("c9_result", 20'h01234);
    tick("c1_out");
    check("c1_result", 20'h0FFFF);

    // Back-to-back distinct sets.
    set_all(16'h0001);
    tick("b2b_n");
    set_all(16'h1000);
    tick("b2b_n1");
    set_all(16'h0100);
    tick("b2b_n2");
    set_all(16'd0);
    tick("b2b_n3");
    check("b2b_first", 20'd9);
    tick("b2b_n4");
    check("b2b_second", 20'h09000);
    tick("b2b_n5");
    check("b2b_third", 20'h00900);

    // Random stream with an input-change probe between edges.
    for (int k = 0; k < 200; k++) begin
      set_rand();
      #1;
      check("no_comb_path", model_sum());
      tick("rand_stream");
    end

    // Mid-stream reset while sets are in flight.
    for (int k = 0; k < 3; k++) begin
      set_all(16'hF0F0 - 16'(k));
      tick("pre_reset_stream");
    end
    rst_n = 1'b1;
    set_rand();
    tick("mid_reset_edge");
    check("mid_reset_zero", 20'd0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_rand();
      tick("post_reset_flush");
      check("post_reset_zero", 20'd0);
    end
    for (int k = 0; k < 100; k++) begin
      set_rand();
      if ($urandom_range(0, 19) == 0) rst_n = 1'b1;
      else rst_n = 1'b0;
      tick("rand_with_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
